// File: rtl/led_matrix_scanner.sv
// Row-scanned LED matrix driver: double-buffered frame store, anti-ghost blanking, global PWM.
// All outputs registered; pins follow the scan counters with one cycle of latency.
module led_matrix_scanner #(
    parameter int   ROWS         = 8,
    parameter int   COLS         = 8,
    parameter int   BRIGHT_W     = 4,
    parameter int   STEP_CYCLES  = 64,
    parameter int   BLANK_CYCLES = 2,
    parameter logic ROW_ON_LEVEL = 1'b1,
    parameter logic COL_ON_LEVEL = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    wr_en,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [COLS-1:0]         wr_data,
    input  logic                    commit,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [ROWS-1:0]         row_pins,
    output logic [COLS-1:0]         col_pins,
    output logic                    frame_start,
    output logic                    swap_pending
);

    localparam int SLOT = BLANK_CYCLES + (2 ** BRIGHT_W) * STEP_CYCLES;
    localparam int PW   = $clog2(SLOT);
    localparam int RW   = $clog2(ROWS);
    localparam logic [ROWS-1:0] ROWS_OFF = {ROWS{~ROW_ON_LEVEL}};
    localparam logic [COLS-1:0] COLS_OFF = {COLS{~COL_ON_LEVEL}};

    logic [COLS-1:0]     bank_q [2][ROWS];
    logic [COLS-1:0]     bank_d [2][ROWS];
    logic                front_q, front_d;
    logic                pend_q, pend_d;
    logic [PW-1:0]       phase_q, phase_d;
    logic [RW-1:0]       row_q, row_d;
    logic [BRIGHT_W-1:0] b_q, b_d;
    logic [ROWS-1:0]     row_pins_q, row_pins_d;
    logic [COLS-1:0]     col_pins_q, col_pins_d;
    logic                frame_start_q, frame_start_d;

    logic                last_phase, frame_end, swap, lit;
    logic [COLS-1:0]     pix;

    always_comb begin
        bank_d        = bank_q;
        front_d       = front_q;
        pend_d        = pend_q;
        phase_d       = phase_q;
        row_d         = row_q;
        b_d           = b_q;
        row_pins_d    = ROWS_OFF;
        col_pins_d    = COLS_OFF;
        frame_start_d = 1'b0;

        last_phase = (phase_q == PW'(SLOT - 1));
        frame_end  = enable && last_phase && (row_q == RW'(ROWS - 1));

        if (enable) begin
            if (last_phase) begin
                phase_d = '0;
                row_d   = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
            end else begin
                phase_d = phase_q + 1'b1;
            end
            if (phase_q == '0) begin
                b_d = brightness;
            end
        end

        // A commit landing exactly on frame end swaps immediately without ever pending.
        swap    = frame_end && (pend_q || commit);
        pend_d  = swap ? 1'b0 : (pend_q || commit);
        front_d = front_q ^ swap;

        // Writes use the pre-swap back bank, so a frame-end write becomes visible at once.
        if (wr_en && (32'(wr_row) < ROWS)) begin
            bank_d[~front_q][wr_row] = wr_data;
        end

        lit = enable
              && (32'(phase_q) >= BLANK_CYCLES)
              && (32'(phase_q) < BLANK_CYCLES + 32'(b_q) * STEP_CYCLES);
        pix = bank_q[front_q][row_q];

        if (lit) begin
            row_pins_d[row_q] = ROW_ON_LEVEL;
            col_pins_d        = pix ^ COLS_OFF;
        end

        frame_start_d = enable && (row_q == '0) && (phase_q == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_q        <= '{default: '0};
            front_q       <= 1'b0;
            pend_q        <= 1'b0;
            phase_q       <= '0;
            row_q         <= '0;
            b_q           <= '0;
            row_pins_q    <= ROWS_OFF;
            col_pins_q    <= COLS_OFF;
            frame_start_q <= 1'b0;
        end else begin
            bank_q        <= bank_d;
            front_q       <= front_d;
            pend_q        <= pend_d;
            phase_q       <= phase_d;
            row_q         <= row_d;
            b_q           <= b_d;
            row_pins_q    <= row_pins_d;
            col_pins_q    <= col_pins_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign row_pins     = row_pins_q;
    assign col_pins     = col_pins_q;
    assign frame_start  = frame_start_q;
    assign swap_pending = pend_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Scoreboarded bench: a time-count reference model predicts every output cycle; a monitor compares.
module tb_led_matrix_scanner;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int BW    = 2;
    localparam int STEP  = 1;
    localparam int BLANK = 2;
    localparam int SLOT  = BLANK + (1 << BW) * STEP;
    localparam int FRAME = ROWS * SLOT;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic          wr_en = 1'b0;
    logic [2:0]    wr_row = '0;
    logic [7:0]    wr_data = '0;
    logic          commit = 1'b0;
    logic [BW-1:0] brightness = 2'd3;
    logic [7:0]    row_pins;
    logic [7:0]    col_pins;
    logic          frame_start;
    logic          swap_pending;

    always #5 clk = ~clk;

    led_matrix_scanner #(
        .ROWS(ROWS), .COLS(COLS), .BRIGHT_W(BW), .STEP_CYCLES(STEP), .BLANK_CYCLES(BLANK)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .wr_en(wr_en), .wr_row(wr_row),
        .wr_data(wr_data), .commit(commit), .brightness(brightness),
        .row_pins(row_pins), .col_pins(col_pins), .frame_start(frame_start),
        .swap_pending(swap_pending)
    );

    typedef struct packed {
        logic [7:0] rows;
        logic [7:0] cols;
        logic       fs;
        logic       sp;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    // Reference model: scan position is simply the count of enabled cycles within the frame.
    logic [7:0] m_bank [2][ROWS];
    logic       m_front;
    logic       m_pend;
    int         m_t;
    int         m_bq;

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < ROWS; r++) m_bank[b][r] = 8'h00;
        m_front = 1'b0;
        m_pend  = 1'b0;
        m_t     = 0;
        m_bq    = 0;
    endtask

    task automatic cycle();
        exp_t e;
        int   row, ph;
        bit   lit, fe, sw;
        if (reset) begin
            e.rows = 8'h00;
            e.cols = 8'hFF;
            e.fs   = 1'b0;
            e.sp   = 1'b0;
            model_reset();
        end else begin
            ph  = m_t % SLOT;
            row = m_t / SLOT;
            lit = enable && (ph >= BLANK) && (ph < BLANK + m_bq * STEP);
            e.rows = lit ? 8'(1 << row) : 8'h00;
            e.cols = lit ? ~m_bank[m_front][row] : 8'hFF;
            e.fs   = enable && (m_t == 0);
            fe = enable && (m_t == FRAME - 1);
            sw = fe && (m_pend || commit);
            if (wr_en) m_bank[~m_front][wr_row] = wr_data;
            if (sw) begin
                m_front = ~m_front;
                m_pend  = 1'b0;
            end else if (commit) begin
                m_pend = 1'b1;
            end
            e.sp = m_pend;
            if (enable && ph == 0) m_bq = int'(brightness);
            if (enable) m_t = (m_t + 1) % FRAME;
        end
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic wr(input int r, input logic [7:0] d);
        wr_en = 1'b1; wr_row = 3'(r); wr_data = d;
        cycle();
        wr_en = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        cycle();
        commit = 1'b0;
    endtask

    task automatic run_until(input int row, input int ph);
        int k = 0;
        while (!((m_t / SLOT) == row && (m_t % SLOT) == ph) && k < 2 * FRAME) begin
            cycle();
            k++;
        end
        if (k >= 2 * FRAME) begin
            n_chk++;
            $display("FAIL run_until row=%0d ph=%0d not reached in %0d cycles", row, ph, k);
        end
    endtask

    always @(posedge clk) begin : monitor
        exp_t e;
        exp_t got;
        #1;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {row_pins, col_pins, frame_start, swap_pending};
            n_chk++;
            if (got === e) n_pass++;
            else $display("FAIL pins t=%0t got rows=%h cols=%h fs=%b sp=%b want rows=%h cols=%h fs=%b sp=%b",
                          $time, got.rows, got.cols, got.fs, got.sp, e.rows, e.cols, e.fs, e.sp);
        end
    end

    initial begin
        @(negedge clk);
        // Reset with scan enabled, full brightness; all-zero banks keep columns dark.
        run(2);
        reset = 1'b0;
        run(100);

        // Single-row pattern committed, shown the frame after the swap.
        wr(2, 8'hA5);
        pulse_commit();
        run(110);

        // Duty sweep, including a mid-slot change that must wait for the next slot.
        brightness = 2'd1; run(50);
        brightness = 2'd0; run(50);
        brightness = 2'd3; run_until(2, 0); run(3);
        brightness = 2'd1; run(20);
        brightness = 2'd3; run(10);

        // Commit plus write exactly on the frame-end cycle.
        run_until(ROWS - 1, SLOT - 1);
        commit = 1'b1; wr_en = 1'b1; wr_row = 3'd7; wr_data = 8'hFF;
        cycle();
        commit = 1'b0; wr_en = 1'b0;
        run(60);

        // Pause mid-row-3 with a commit issued while disabled.
        wr(5, 8'h3C);
        run_until(3, 2);
        enable = 1'b0; run(5);
        pulse_commit(); run(14);
        enable = 1'b1; run(120);

        // Reset mid-frame with a pending swap.
        wr(1, 8'h81);
        pulse_commit(); run(10);
        reset = 1'b1; cycle();
        reset = 1'b0; run(60);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            enable  = ($urandom_range(0, 9) != 0);
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_row  = 3'($urandom_range(0, 7));
            wr_data = 8'($urandom);
            commit  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 49) == 0) brightness = 2'($urandom);
            reset   = ($urandom_range(0, 799) == 0);
            cycle();
        end
        reset = 1'b0; wr_en = 1'b0; commit = 1'b0;

        @(posedge clk); @(posedge clk); #2;
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain got %0d entries left want 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/led_matrix_scanner.md
# led_matrix_scanner

Parametrised, time-multiplexed driver for a row/column LED matrix on the PMOD headers. It replaces static switch-to-pin wiring with a double-buffered frame store, row scanning, anti-ghost blanking, global PWM brightness and configurable pin polarity. The CPU or the switch logic writes rows into a back buffer and commits them. The scanner swaps buffers only at frame boundaries, so frames never tear. Board top-levels map `row_pins`/`col_pins` onto `ja`/`jb` with pure wiring.

## Interface
- `ROWS`, 8, number of matrix rows scanned (≥2)
- `COLS`, 8, number of columns per row (≥1)
- `BRIGHT_W`, 4, brightness width; `2**BRIGHT_W` PWM steps per row slot
- `STEP_CYCLES`, 64, clocks per PWM step (≥1)
- `BLANK_CYCLES`, 2, all-off clocks at the start of every row slot (≥1)
- `ROW_ON_LEVEL`, 1, pin level that selects a row
- `COL_ON_LEVEL`, 0, pin level that lights a column

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `enable`  in  1  scan enable; low = blank and hold
- `wr_en`  in  1  write one row of the back buffer
- `wr_row`  in  $clog2(ROWS)  row address for the write
- `wr_data`  in  COLS  pixel bits; bit c = column c, 1 = lit
- `commit`  in  1  pulse: request back/front swap at the next frame end
- `brightness`  in  BRIGHT_W  global duty, 0 = dark
- `row_pins`  out  ROWS  physical row drive
- `col_pins`  out  COLS  physical column drive
- `frame_start`  out  1  1-cycle pulse, first cycle of row 0 slot
- `swap_pending`  out  1  commit accepted, swap not yet done

## Operation
- Frame store: two ROWS×COLS register banks and a `front` select bit. Writes always go to bank `~front`. A write with `wr_row ≥ ROWS` is ignored. Banks are never copied: after a swap, the new back bank holds the frame from two commits ago.
- Scan counters: `phase` counts 0..SLOT-1, where SLOT = BLANK_CYCLES + 2**BRIGHT_W × STEP_CYCLES. `row` counts 0..ROWS-1 and wraps to 0. `row` advances when `phase` = SLOT-1.
- `brightness` is sampled into `b_q` at `phase` = 0 of every slot.
- Row is lit when BLANK_CYCLES ≤ `phase` < BLANK_CYCLES + `b_q` × STEP_CYCLES. When lit:
  - `row_pins[row]` = ROW_ON_LEVEL; all other rows ≠ ROW_ON_LEVEL.
  - `col_pins[c]` = COL_ON_LEVEL iff front bank pixel (row, c) = 1.
- Otherwise all pins are inactive: rows = ~ROW_ON_LEVEL, cols = ~COL_ON_LEVEL.
- Frame end is the cycle with `row` = ROWS-1 and `phase` = SLOT-1.
- `commit` sets the pending flag. At frame end, if pending is set or `commit` is high in that same cycle:
  - `front` toggles and pending clears.
  - A `wr_en` in that cycle still targets the pre-toggle back bank, so it is displayed.
- `commit` while pending is already set has no extra effect.
- `enable` = 0:
  - `phase`, `row` and `front` hold.
  - Pins are inactive and `frame_start` = 0.
  - Writes and commits are still accepted. Swaps wait until scanning resumes and reaches frame end.
- Reset:
  - Both banks = 0, `front` = 0, `row` = 0, `phase` = 0, `b_q` = 0, pending = 0.
  - `row_pins` = {ROWS{~ROW_ON_LEVEL}}, `col_pins` = {COLS{~COL_ON_LEVEL}}, `frame_start` = 0, `swap_pending` = 0.
  - A reset mid-frame aborts the frame and drops any pending swap.

## Timing
- All outputs are registered. Pins reflect the counter state of the previous cycle (1-cycle latency).
- `frame_start` is high in the cycle whose pins show row 0, `phase` 0. The first pulse comes 1 cycle after the first enabled cycle following reset.
- `swap_pending` rises 1 cycle after `commit` and falls 1 cycle after the frame-end swap.
- New content appears on pins starting with the row 0 slot after the swap, delayed by 1 cycle.
- Brightness changes take effect at the next slot boundary, never mid-slot.
- Frame period is ROWS × SLOT enabled cycles. With defaults: 8 × 1026 = 8208 cycles, about 12.2 kHz at 100 MHz.

## Test plan
Parameters: ROWS=8, COLS=8, BRIGHT_W=2, STEP_CYCLES=1, BLANK_CYCLES=2, so SLOT=6 and frame=48.

1. Reset with `enable`=1 and `brightness`=3 -> pins idle: rows=8'h00, cols=8'hFF; `frame_start` pulses every 48 cycles; cols stay 8'hFF (all banks zero).
2. Write row 2 = 8'hA5, then `commit` -> `swap_pending`=1 until frame end. Next frame, row 2 slot: `row_pins`=8'h04 and `col_pins`=8'h5A on slot cycles 2..4, idle on cycles 0, 1 and 5. All other rows idle.
3. `brightness`=1 -> each row lit exactly 1 cycle per slot. `brightness`=0 -> no pin ever active. Change brightness mid-slot -> the current slot keeps the old duty.
4. `commit` and `wr_en` (row 7 = 8'hFF) in the frame-end cycle -> swap occurs; row 7 shows cols=8'h00 in the very next frame. `swap_pending` never rises.
5. Drop `enable` for 20 cycles mid-row-3 -> pins idle, counters frozen, `frame_start` absent. Resume -> row 3 slot continues from the same phase. A `commit` issued while disabled swaps at the first frame end after resume.
6. Assert `reset` mid-frame with a commit pending -> next cycle: pins idle, `swap_pending`=0, both banks zero, scan restarts at row 0.
